// File: rtl/sr_register_bank.sv
// rtl/sr_register_bank.sv - clocked set/reset flag bank with edge pulses, popcount and conflict flag
// Selectable S=R=1 resolution replaces the forbidden state of the legacy NAND SR latch.
module sr_register_bank #(
  parameter int               WIDTH = 4,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_BAR,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [CW-1:0]    COUNT,
  output logic             ANY,
  output logic             ALL,
  output logic             CONFLICT
);

  localparam int MODE_RESET_DOM = 0;
  localparam int MODE_SET_DOM   = 1;
  localparam int MODE_HOLD      = 2;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic [CW-1:0]    count_reg;
  logic             conflict_reg;
  logic             conflict_next;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // S/R are only examined when EN is high and CLR is low, so X there cannot reach Q.
  always_comb begin
    q_next        = q_reg;
    conflict_next = 1'b0;
    if (CLR) begin
      q_next = '0;
    end else if (EN) begin
      conflict_next = |(S & R);
      for (int i = 0; i < WIDTH; i++) begin
        case ({S[i], R[i]})
          2'b10:   q_next[i] = 1'b1;
          2'b01:   q_next[i] = 1'b0;
          2'b11: begin
            case (MODE)
              MODE_RESET_DOM: q_next[i] = 1'b0;
              MODE_SET_DOM:   q_next[i] = 1'b1;
              MODE_HOLD:      q_next[i] = q_reg[i];
              default:        q_next[i] = ~q_reg[i];
            endcase
          end
          default: q_next[i] = q_reg[i];
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg        <= INIT;
      rise_reg     <= '0;
      fall_reg     <= '0;
      count_reg    <= popcount(INIT);
      conflict_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      rise_reg     <= ~q_reg & q_next;
      fall_reg     <= q_reg & ~q_next;
      count_reg    <= popcount(q_next);
      conflict_reg <= conflict_next;
    end
  end

  assign Q        = q_reg;
  assign Q_BAR    = ~q_reg;
  assign RISE     = rise_reg;
  assign FALL     = fall_reg;
  assign COUNT    = count_reg;
  assign ANY      = |q_reg;
  assign ALL      = &q_reg;
  assign CONFLICT = conflict_reg;

endmodule

// File: tb/tb_sr_register_bank.sv
// tb/tb_sr_register_bank.sv - directed bench for sr_register_bank across all four conflict modes
// Four instances share stimulus; each differs in MODE and INIT.
module tb_sr_register_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] s;
  logic [3:0] r;

  logic [3:0] q     [4];
  logic [3:0] qb    [4];
  logic [3:0] rise  [4];
  logic [3:0] fall  [4];
  logic [2:0] cnt   [4];
  logic       any_o [4];
  logic       all_o [4];
  logic       conf  [4];

  int checks;
  int errors;

  sr_register_bank #(.WIDTH(4), .MODE(0), .INIT(4'b1010)) u0 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .S(s), .R(r),
    .Q(q[0]), .Q_BAR(qb[0]), .RISE(rise[0]), .FALL(fall[0]), .COUNT(cnt[0]),
    .ANY(any_o[0]), .ALL(all_o[0]), .CONFLICT(conf[0]));

  sr_register_bank #(.WIDTH(4), .MODE(1), .INIT(4'b0011)) u1 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .S(s), .R(r),
    .Q(q[1]), .Q_BAR(qb[1]), .RISE(rise[1]), .FALL(fall[1]), .COUNT(cnt[1]),
    .ANY(any_o[1]), .ALL(all_o[1]), .CONFLICT(conf[1]));

  sr_register_bank #(.WIDTH(4), .MODE(2), .INIT(4'b0000)) u2 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .S(s), .R(r),
    .Q(q[2]), .Q_BAR(qb[2]), .RISE(rise[2]), .FALL(fall[2]), .COUNT(cnt[2]),
    .ANY(any_o[2]), .ALL(all_o[2]), .CONFLICT(conf[2]));

  sr_register_bank #(.WIDTH(4), .MODE(3), .INIT(4'b1010)) u3 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .S(s), .R(r),
    .Q(q[3]), .Q_BAR(qb[3]), .RISE(rise[3]), .FALL(fall[3]), .COUNT(cnt[3]),
    .ANY(any_o[3]), .ALL(all_o[3]), .CONFLICT(conf[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; s = 4'b0000; r = 4'b0000;
    tick();
    tick();

    check("rst_q",        32'(q[0]),     32'b1010);
    check("rst_qbar",     32'(qb[0]),    32'b0101);
    check("rst_count",    32'(cnt[0]),   32'd2);
    check("rst_any",      32'(any_o[0]), 32'd1);
    check("rst_all",      32'(all_o[0]), 32'd0);
    check("rst_rise",     32'(rise[0]),  32'd0);
    check("rst_fall",     32'(fall[0]),  32'd0);
    check("rst_conflict", 32'(conf[0]),  32'd0);
    check("rst_q_init1",  32'(q[1]),     32'b0011);

    rst = 1'b0; clr = 1'b1;
    tick();
    check("clr_q",     32'(q[0]),    32'b0000);
    check("clr_fall",  32'(fall[0]), 32'b1010);
    check("clr_count", 32'(cnt[0]),  32'd0);

    clr = 1'b0; en = 1'b1; s = 4'b0011; r = 4'b0000;
    tick();
    check("set_q",        32'(q[2]),    32'b0011);
    check("set_rise",     32'(rise[2]), 32'b0011);
    check("set_count",    32'(cnt[2]),  32'd2);
    check("set_conflict", 32'(conf[2]), 32'd0);

    s = 4'b0000; r = 4'b0001;
    tick();
    check("reset_q",     32'(q[2]),    32'b0010);
    check("reset_fall",  32'(fall[2]), 32'b0001);
    check("reset_rise",  32'(rise[2]), 32'b0000);
    check("reset_count", 32'(cnt[2]),  32'd1);

    r = 4'b0000;
    tick();
    check("idle_q",    32'(q[2]),    32'b0010);
    check("idle_rise", 32'(rise[2]), 32'd0);
    check("idle_fall", 32'(fall[2]), 32'd0);

    // Independent set and reset on different bits in one cycle: no conflict.
    s = 4'b0101; r = 4'b0010;
    tick();
    check("mixed_q",        32'(q[2]),    32'b0101);
    check("mixed_conflict", 32'(conf[2]), 32'd0);
    check("mixed_q_mode0",  32'(q[0]),    32'b0101);

    s = 4'b1111; r = 4'b1111;
    tick();
    check("mode0_q",    32'(q[0]), 32'b0000);
    check("mode1_q",    32'(q[1]), 32'b1111);
    check("mode2_q",    32'(q[2]), 32'b0101);
    check("mode3_q",    32'(q[3]), 32'b1010);
    check("mode3_rise", 32'(rise[3]), 32'b1010);
    check("mode3_fall", 32'(fall[3]), 32'b0101);
    check("mode0_conflict", 32'(conf[0]), 32'd1);
    check("mode1_conflict", 32'(conf[1]), 32'd1);
    check("mode2_conflict", 32'(conf[2]), 32'd1);
    check("mode3_conflict", 32'(conf[3]), 32'd1);

    s = 4'b0000; r = 4'b0000;
    tick();
    check("conflict_drop", 32'(conf[3]), 32'd0);
    check("mode3_hold_q",  32'(q[3]),    32'b1010);

    clr = 1'b1;
    tick();
    clr = 1'b0; s = 4'b0110;
    tick();
    check("gate_setup_q", 32'(q[2]), 32'b0110);

    en = 1'b0; s = 4'b1111; r = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gate_q",     32'(q[2]),    32'b0110);
      check("gate_rise",  32'(rise[2]), 32'd0);
      check("gate_count", 32'(cnt[2]),  32'd2);
    end
    s = 4'bxxxx; r = 4'bxxxx;
    tick();
    check("gate_x_q", 32'(q[2]), 32'b0110);
    check("gate_x_conflict", 32'(conf[2]), 32'd0);

    en = 1'b1; s = 4'b1111; r = 4'b0000;
    tick();
    check("ungate_q",     32'(q[2]),     32'b1111);
    check("ungate_all",   32'(all_o[2]), 32'd1);
    check("ungate_count", 32'(cnt[2]),   32'd4);
    check("ungate_rise",  32'(rise[2]),  32'b1001);

    clr = 1'b1; s = 4'b1111; r = 4'b1111;
    tick();
    check("clrpri_q",        32'(q[2]),    32'b0000);
    check("clrpri_q_mode1",  32'(q[1]),    32'b0000);
    check("clrpri_fall",     32'(fall[2]), 32'b1111);
    check("clrpri_count",    32'(cnt[2]),  32'd0);
    check("clrpri_conflict", 32'(conf[2]), 32'd0);

    rst = 1'b1;
    tick();
    check("rstclr_q",    32'(q[1]),    32'b0011);
    check("rstclr_rise", 32'(rise[1]), 32'd0);
    check("rstclr_fall", 32'(fall[1]), 32'd0);

    rst = 1'b0; clr = 1'b0; en = 1'b1; s = 4'b1111; r = 4'b1111;
    tick();
    check("tog1_q", 32'(q[3]), 32'b0101);
    tick();
    check("tog2_q", 32'(q[3]), 32'b1010);
    tick();
    check("tog3_q", 32'(q[3]), 32'b0101);

    rst = 1'b1;
    tick();
    check("midrst_q",        32'(q[3]),    32'b1010);
    check("midrst_qbar",     32'(qb[3]),   32'b0101);
    check("midrst_rise",     32'(rise[3]), 32'd0);
    check("midrst_fall",     32'(fall[3]), 32'd0);
    check("midrst_conflict", 32'(conf[3]), 32'd0);

    rst = 1'b0;
    tick();
    check("resume_q",        32'(q[3]),    32'b0101);
    check("resume_rise",     32'(rise[3]), 32'b0101);
    check("resume_fall",     32'(fall[3]), 32'b1010);
    check("resume_conflict", 32'(conf[3]), 32'd1);
    check("resume_count",    32'(cnt[3]),  32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_register_bank.md
Name: sr_register_bank

Overview:
- Parametrised bank of WIDTH clocked set/reset storage elements. It is the synchronous successor to the NAND cross-coupled SR latch.
- Each bit has its own set and reset inputs.
- The resolution of simultaneous set and reset is selectable, replacing the latch's forbidden state.
- The block also produces registered edge pulses, a set-bit population count and a conflict flag. It sits in the DFF/SR library as the standard status/flag holding block for lab datapaths.

Parameters:
- WIDTH, 4: number of independent SR bits (1..32).
- MODE, 0: S=R=1 resolution. 0 = reset-dominant, 1 = set-dominant, 2 = hold, 3 = toggle.
- INIT, 0: WIDTH-bit value loaded into Q on reset.
- CW, $clog2(WIDTH+1): width of COUNT (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  update enable for S/R.
- CLR  input  1  synchronous clear of all bits to 0.
- S  input  WIDTH  per-bit set request.
- R  input  WIDTH  per-bit reset request.
- Q  output  WIDTH  stored state (registered).
- Q_BAR  output  WIDTH  always the bitwise complement of Q.
- RISE  output  WIDTH  one-cycle pulse per bit that went 0->1 at the last edge.
- FALL  output  WIDTH  one-cycle pulse per bit that went 1->0 at the last edge.
- COUNT  output  CW  number of 1 bits in Q (registered, same cycle as Q).
- ANY  output  1  |Q (combinational from Q).
- ALL  output  1  &Q (combinational from Q).
- CONFLICT  output  1  registered; 1 if any bit had S=R=1 with EN=1 at the last edge.

Behaviour:
- All state updates occur on the rising edge of CLK. Priority is RST > CLR > EN.
- RST=1 sets: Q=INIT, Q_BAR=~INIT, RISE=0, FALL=0, COUNT=popcount(INIT), CONFLICT=0. No pulses are generated by reset, including reset asserted mid-operation.
- CLR=1 (RST=0):
  - Q <= 0 and COUNT <= 0, regardless of EN, S and R.
  - FALL <= old Q; RISE <= 0; CONFLICT <= 0.
- EN=1 (RST=0, CLR=0), per bit i:
  - S=0, R=0: hold.
  - S=1, R=0: Q=1.
  - S=0, R=1: Q=0.
  - S=1, R=1: MODE 0 gives 0; MODE 1 gives 1; MODE 2 holds; MODE 3 gives ~Q.
- CONFLICT <= |(S & R) when EN=1, independent of MODE.
- EN=0 (RST=0, CLR=0): Q holds; RISE, FALL and CONFLICT <= 0; COUNT holds.
- Edge pulses on every non-reset edge: RISE <= ~Qold & Qnew; FALL <= Qold & ~Qnew. Pulses last exactly one cycle unless the bit changes again.
- COUNT:
  - Computed from Qnew and registered with Q, so it has zero extra latency relative to Q.
  - Range is 0..WIDTH and it never wraps; CW is sized to hold WIDTH.
- Latency: a request on S/R is visible on Q, Q_BAR, COUNT, ANY, ALL, RISE and FALL after exactly 1 clock edge.
- Q_BAR is derived from Q, never stored separately, so Q == ~Q_BAR holds at all times including after reset.
- Bits are fully independent. Setting and resetting different bits in the same cycle is legal and does not raise CONFLICT.
- X on S/R while EN=0, or while CLR/RST=1, must not propagate into Q.

Test Plan:
- Reset, WIDTH=4, INIT=4'b1010: assert RST 2 cycles -> Q=1010, Q_BAR=0101, COUNT=2, ANY=1, ALL=0, RISE=FALL=0, CONFLICT=0.
- Set/reset from Q=0000, EN=1: S=0011, R=0000 -> next cycle Q=0011, RISE=0011, COUNT=2. Then S=0000, R=0001 -> Q=0010, FALL=0001, RISE=0000, COUNT=1. Idle cycle -> RISE=FALL=0.
- Conflict per MODE from Q=0101, S=R=1111, EN=1:
  - MODE0 -> Q=0000.
  - MODE1 -> Q=1111.
  - MODE2 -> Q=0101.
  - MODE3 -> Q=1010, RISE=1010, FALL=0101.
  - In all four modes CONFLICT=1 for one cycle.
- Enable gating: Q=0110, EN=0, S=1111, R=0000 for 3 cycles -> Q stays 0110, RISE=0, COUNT=2. Raise EN -> Q=1111, ALL=1, COUNT=4.
- Clear priority: Q=1111, CLR=1, EN=1, S=1111 -> Q=0000, FALL=1111, COUNT=0, CONFLICT=0. Then RST and CLR together with INIT=0011 -> Q=0011 and no pulses.
- Reset mid-operation: toggle MODE3 running with S=R=1111 every cycle, assert RST for 1 cycle -> Q=INIT, RISE=FALL=CONFLICT=0 that cycle, and toggling resumes from INIT next cycle.
